// File: rtl/clk_gen_tune_ctrl.sv
// clk_gen_tune_ctrl
//   Closed-loop tuning controller for the tunable ring-oscillator clock
//   generator. Each window it counts synchronized oscillator ticks over a
//   fixed number of reference-clock cycles, compares the count with a target,
//   and steps the delay-stage select code up (slower) or down (faster) until
//   the count is within tolerance, at which point lock is asserted.
//
// Ports
//   clk_i         reference clock
//   reset_i       asynchronous active-high reset
//   en_i          run controller; low forces IDLE
//   manual_i      bypass the loop and drive manual_sel_i onto the ring
//   manual_sel_i  select code used in manual mode
//   target_i      desired ticks per window (sampled in ADJUST only)
//   osc_tick_i    one-cycle pulse per oscillator edge, already synchronized
//   osc_en_o      ring oscillator enable
//   sel_o         stage-select code to the ring (0 = shortest/fastest)
//   lock_o        last count was within tolerance
//   sat_o         loop wanted to step past code 0 or the max code
//   meas_count_o  last completed window count
//   meas_valid_o  one-cycle pulse when meas_count_o updates
module clk_gen_tune_ctrl #(
    parameter int SEL_W         = 3,
    parameter int CNT_W         = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int TOL           = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             manual_i,
    input  logic [SEL_W-1:0] manual_sel_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic             osc_tick_i,
    output logic             osc_en_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             lock_o,
    output logic             sat_o,
    output logic [CNT_W-1:0] meas_count_o,
    output logic             meas_valid_o
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SEL_W-1:0] SEL_MID  = SEL_W'(2 ** (SEL_W - 1));
    localparam logic [SEL_W-1:0] SEL_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W + 1)'(TOL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_ADJUST,
        S_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             lock_q, lock_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic             meas_valid_q, meas_valid_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic             manual_q;

    // Tick counter saturates at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic             t);
        if (t && (c != '1))
            return c + CNT_W'(1);
        return c;
    endfunction

    logic [CNT_W:0]   cnt_x;
    logic [CNT_W:0]   tgt_x;
    logic             too_many;
    logic             too_few;
    logic             manual_fall;

    // One extra bit so target+TOL and count+TOL can never overflow.
    assign cnt_x       = {1'b0, meas_count_q};
    assign tgt_x       = {1'b0, target_i};
    assign too_many    = cnt_x > (tgt_x + TOL_X);
    assign too_few     = (cnt_x + TOL_X) < tgt_x;
    assign manual_fall = manual_q && !manual_i;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        lock_d       = lock_q;
        sat_d        = sat_q;
        meas_count_d = meas_count_q;
        meas_valid_d = 1'b0;
        settle_d     = settle_q;
        win_d        = win_q;
        tick_d       = tick_q;

        case (state_q)
            S_IDLE: begin
                lock_d = 1'b0;
                if (en_i) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    state_d = S_MEASURE;
                    win_d   = '0;
                    tick_d  = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_MEASURE: begin
                // The tick on the final window cycle is included in the result.
                tick_d = sat_inc(tick_q, osc_tick_i);
                if (win_q == WIN_LAST) begin
                    meas_count_d = tick_d;
                    meas_valid_d = 1'b1;
                    state_d      = S_ADJUST;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            S_ADJUST: begin
                settle_d = '0;
                if (manual_i) begin
                    // Manual mode keeps measuring but never moves the code.
                    state_d = S_SETTLE;
                end else if (too_many) begin
                    state_d = S_SETTLE;
                    lock_d  = 1'b0;
                    if (sel_q == SEL_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                        sat_d = 1'b0;
                    end
                end else if (too_few) begin
                    state_d = S_SETTLE;
                    lock_d  = 1'b0;
                    if (sel_q == '0) begin
                        sat_d = 1'b1;
                    end else begin
                        sel_d = sel_q - SEL_W'(1);
                        sat_d = 1'b0;
                    end
                end else begin
                    state_d = S_LOCKED;
                    lock_d  = 1'b1;
                    sat_d   = 1'b0;
                end
            end
            S_LOCKED: begin
                // Code unchanged, so the next window starts without settling.
                state_d = S_MEASURE;
                win_d   = '0;
                tick_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (en_i && manual_i) begin
            sel_d  = manual_sel_i;
            lock_d = 1'b0;
            sat_d  = 1'b0;
        end

        // Leaving manual mode: the ring may have moved, so settle first.
        if (en_i && manual_fall) begin
            state_d      = S_SETTLE;
            settle_d     = '0;
            meas_valid_d = 1'b0;
            meas_count_d = meas_count_q;
        end

        // Disable wins over everything; the partial window is discarded.
        if (!en_i) begin
            state_d      = S_IDLE;
            lock_d       = 1'b0;
            sel_d        = sel_q;
            meas_valid_d = 1'b0;
            meas_count_d = meas_count_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            sel_q        <= SEL_MID;
            lock_q       <= 1'b0;
            sat_q        <= 1'b0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            settle_q     <= '0;
            win_q        <= '0;
            tick_q       <= '0;
            manual_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            lock_q       <= lock_d;
            sat_q        <= sat_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            settle_q     <= settle_d;
            win_q        <= win_d;
            tick_q       <= tick_d;
            manual_q     <= manual_i;
        end
    end

    assign osc_en_o     = (state_q != S_IDLE);
    assign sel_o        = sel_q;
    assign lock_o       = lock_q;
    assign sat_o        = sat_q;
    assign meas_count_o = meas_count_q;
    assign meas_valid_o = meas_valid_q;

endmodule

// File: tb/tb_clk_gen_tune_ctrl.sv
module tb_clk_gen_tune_ctrl;

    localparam int SEL_W = 3;
    localparam int CNT_W = 16;
    localparam int WIN   = 256;
    localparam int SET   = 16;
    localparam int TOL   = 2;
    localparam int S_CNT_W = 8;
    localparam int S_WIN   = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic             reset_i = 1'b1;
    logic             en_i = 1'b0;
    logic             manual_i = 1'b0;
    logic [SEL_W-1:0] manual_sel_i = '0;
    logic [CNT_W-1:0] target_i = '0;
    logic             osc_tick_i = 1'b0;
    logic             osc_en_o;
    logic [SEL_W-1:0] sel_o;
    logic             lock_o;
    logic             sat_o;
    logic [CNT_W-1:0] meas_count_o;
    logic             meas_valid_o;

    clk_gen_tune_ctrl #(
        .SEL_W(SEL_W), .CNT_W(CNT_W), .WINDOW_CYCLES(WIN),
        .SETTLE_CYCLES(SET), .TOL(TOL)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .manual_i(manual_i),
        .manual_sel_i(manual_sel_i), .target_i(target_i), .osc_tick_i(osc_tick_i),
        .osc_en_o(osc_en_o), .sel_o(sel_o), .lock_o(lock_o), .sat_o(sat_o),
        .meas_count_o(meas_count_o), .meas_valid_o(meas_valid_o)
    );

    // Narrow-counter instance for the saturation case
    logic               s_reset = 1'b1;
    logic               s_en = 1'b0;
    logic               s_manual = 1'b0;
    logic [SEL_W-1:0]   s_manual_sel = '0;
    logic [S_CNT_W-1:0] s_target = '0;
    logic               s_tick = 1'b1;
    logic               s_osc_en;
    logic [SEL_W-1:0]   s_sel;
    logic               s_lock;
    logic               s_sat;
    logic [S_CNT_W-1:0] s_meas_count;
    logic               s_meas_valid;

    clk_gen_tune_ctrl #(
        .SEL_W(SEL_W), .CNT_W(S_CNT_W), .WINDOW_CYCLES(S_WIN),
        .SETTLE_CYCLES(SET), .TOL(TOL)
    ) dut_sat (
        .clk_i(clk), .reset_i(s_reset), .en_i(s_en), .manual_i(s_manual),
        .manual_sel_i(s_manual_sel), .target_i(s_target), .osc_tick_i(s_tick),
        .osc_en_o(s_osc_en), .sel_o(s_sel), .lock_o(s_lock), .sat_o(s_sat),
        .meas_count_o(s_meas_count), .meas_valid_o(s_meas_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Oscillator stub: rate_tbl[code] ticks in any WIN consecutive cycles
    // (phase accumulator, so the count over a window of constant rate is exact).
    int rate_tbl[8];
    int acc = 0;
    always @(negedge clk) begin
        acc = acc + rate_tbl[sel_o];
        if (acc >= WIN) begin
            osc_tick_i = 1'b1;
            acc = acc - WIN;
        end else begin
            osc_tick_i = 1'b0;
        end
    end

    int vld_cycles = 0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (meas_valid_o) vld_cycles <= vld_cycles + 1;
    end

    task automatic set_rates(input int r);
        for (int s = 0; s < 8; s++) rate_tbl[s] = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        en_i = 1'b0;
        manual_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    // Wait (bounded) for a meas_valid pulse; leaves us at the negedge of that cycle.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (meas_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: no meas_valid_o within 2000 cycles");
        end
    endtask

    // Returns window count and the code it was measured at; ends one cycle
    // after the pulse, when the adjust decision is visible.
    task automatic run_window(output int cnt, output int sel_w);
        bit ok;
        wait_valid(ok);
        cnt = meas_count_o;
        sel_w = sel_o;
        @(negedge clk);
        chk("valid_one_cycle", meas_valid_o, 0);
    endtask

    // Window-level loop model
    function automatic void model_step(input int c, input int t, input int sel_in,
                                       output int sel_out, output int lk, output int st);
        sel_out = sel_in;
        lk = 0;
        st = 0;
        if (c > t + TOL) begin
            if (sel_in == 7) st = 1; else sel_out = sel_in + 1;
        end else if (c + TOL < t) begin
            if (sel_in == 0) st = 1; else sel_out = sel_in - 1;
        end else begin
            lk = 1;
        end
    endfunction

    typedef struct {
        int target;
        int rate;
        int exp_sel;
        int exp_lock;
        int exp_sat;
    } vec_t;
    vec_t tbl[10];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, sw, v0, c1, c2, sel_m, sel_n, lk, st;
        bit ok;

        tbl[0] = '{100, 102, 4, 1, 0};
        tbl[1] = '{100,  98, 4, 1, 0};
        tbl[2] = '{100, 103, 5, 0, 0};
        tbl[3] = '{100,  97, 3, 0, 0};
        tbl[4] = '{100, 100, 4, 1, 0};
        tbl[5] = '{  0,   3, 5, 0, 0};
        tbl[6] = '{  0,   2, 4, 1, 0};
        tbl[7] = '{  1,   0, 4, 1, 0};
        tbl[8] = '{65534, 256, 3, 0, 0};
        tbl[9] = '{ 40, 255, 5, 0, 0};

        set_rates(0);
        repeat (3) @(negedge clk);
        chk("rst_osc_en", osc_en_o, 0);
        chk("rst_sel", sel_o, 4);
        chk("rst_lock", lock_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_meas_count", meas_count_o, 0);
        chk("rst_meas_valid", meas_valid_o, 0);
        reset_i = 1'b0;
        s_reset = 1'b0;
        s_en = 1'b1;

        // Test 1: converge upward 4->7
        for (int s = 0; s < 8; s++) rate_tbl[s] = 130 - 10 * (s - 4);
        target_i = 100;
        v0 = vld_cycles;
        en_i = 1'b1;
        @(negedge clk);
        chk("t1_osc_en", osc_en_o, 1);
        for (int k = 0; k < 4; k++) begin
            run_window(cnt, sw);
            chk("t1_count", cnt, 130 - 10 * k);
            chk("t1_sel_meas", sw, 4 + k);
            chk("t1_sel_after", sel_o, (k < 3) ? 5 + k : 7);
            chk("t1_lock", lock_o, (k == 3) ? 1 : 0);
        end
        chk("t1_pulses", vld_cycles - v0, 4);

        // Test 6c: asynchronous reset mid-window
        repeat (100) @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("rst_mid_sel", sel_o, 4);
        chk("rst_mid_lock", lock_o, 0);
        chk("rst_mid_osc_en", osc_en_o, 0);
        chk("rst_mid_count", meas_count_o, 0);
        chk("rst_mid_valid", meas_valid_o, 0);
        en_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;

        // Test 5: saturating counter on the narrow instance (runs from time 0)
        ok = 1'b0;
        for (int i = 0; i < 1500 && !ok; i++) begin
            if (s_meas_valid) ok = 1'b1; else @(negedge clk);
        end
        chk("t5_valid_seen", ok, 1);
        chk("t5_count_sat", s_meas_count, 255);

        // Test 2: rate too low everywhere -> walk to 0, then saturate
        do_reset();
        set_rates(80);
        target_i = 100;
        en_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_window(cnt, sw);
            chk("t2_count", cnt, 80);
            chk("t2_sel", sel_o, (k < 4) ? 3 - k : 0);
            chk("t2_sat", sat_o, (k >= 4) ? 1 : 0);
            chk("t2_lock", lock_o, 0);
        end

        // Test 3: tolerance table
        foreach (tbl[i]) begin
            do_reset();
            set_rates(tbl[i].rate);
            target_i = CNT_W'(tbl[i].target);
            en_i = 1'b1;
            run_window(cnt, sw);
            chk("t3_count", cnt, tbl[i].rate);
            chk("t3_sel", sel_o, tbl[i].exp_sel);
            chk("t3_lock", lock_o, tbl[i].exp_lock);
            chk("t3_sat", sat_o, tbl[i].exp_sat);
        end

        // Test 4: locked, then drift out of tolerance
        do_reset();
        set_rates(100);
        target_i = 100;
        en_i = 1'b1;
        run_window(cnt, sw);
        chk("t4_locked", lock_o, 1);
        set_rates(106);
        wait_valid(ok);
        c1 = cyc;
        chk("t4_count", meas_count_o, 106);
        chk("t4_lock_held", lock_o, 1);
        @(negedge clk);
        chk("t4_lock_drop", lock_o, 0);
        chk("t4_sel_step", sel_o, 5);
        wait_valid(ok);
        c2 = cyc;
        chk("t4_resettle_len", c2 - c1, 1 + SET + WIN);

        // Test 6a: en_i dropped mid-MEASURE
        do_reset();
        set_rates(130);
        target_i = 100;
        en_i = 1'b1;
        run_window(cnt, sw);
        repeat (SET + 100) @(negedge clk);
        chk("t6_osc_en_run", osc_en_o, 1);
        v0 = vld_cycles;
        en_i = 1'b0;
        @(negedge clk);
        chk("t6_osc_en_off", osc_en_o, 0);
        chk("t6_lock_off", lock_o, 0);
        repeat (400) @(negedge clk);
        chk("t6_no_pulse", vld_cycles - v0, 0);
        chk("t6_sel_kept", sel_o, 5);
        chk("t6_count_kept", meas_count_o, 130);

        // Test 6b: manual mode
        en_i = 1'b1;
        manual_i = 1'b1;
        manual_sel_i = 3'd2;
        #1;
        chk("t6_man_latency", sel_o, 5);
        @(negedge clk);
        chk("t6_man_sel", sel_o, 2);
        chk("t6_man_lock", lock_o, 0);
        chk("t6_man_sat", sat_o, 0);
        run_window(cnt, sw);
        chk("t6_man_count", cnt, 130);
        chk("t6_man_sel_hold", sel_o, 2);
        manual_sel_i = 3'd6;
        @(negedge clk);
        @(negedge clk);
        chk("t6_man_sel6", sel_o, 6);
        manual_i = 1'b0;
        run_window(cnt, sw);
        chk("t6_auto_sel", sel_o, 7);
        chk("t6_auto_sat0", sat_o, 0);
        run_window(cnt, sw);
        chk("t6_auto_sel_max", sel_o, 7);
        chk("t6_auto_sat1", sat_o, 1);
        chk("t6_auto_lock", lock_o, 0);

        // Randomized rate tables and targets against the window-level model
        for (int it = 0; it < 3; it++) begin
            do_reset();
            for (int s = 0; s < 8; s++) rate_tbl[s] = $urandom_range(0, 256);
            target_i = CNT_W'($urandom_range(0, 260));
            en_i = 1'b1;
            sel_m = 4;
            for (int w = 0; w < 6; w++) begin
                run_window(cnt, sw);
                chk("rnd_sel_meas", sw, sel_m);
                chk("rnd_count", cnt, rate_tbl[sel_m]);
                model_step(rate_tbl[sel_m], int'(target_i), sel_m, sel_n, lk, st);
                chk("rnd_sel", sel_o, sel_n);
                chk("rnd_lock", lock_o, lk);
                chk("rnd_sat", sat_o, st);
                sel_m = sel_n;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
